// File: rtl/blink_sched_pkg.sv
// Shared types, default parameters and the round-robin helper for blink_scheduler.
// The optional abort input is enabled with the BLINK_SCHED_ABORT_EN macro (see blink_scheduler).
package blink_sched_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_e;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_CODE_W      = 4;
  localparam int DEF_CLK_FREQ_HZ = 1_000_000_000;
  localparam int DEF_TICK_HZ     = 10;
  localparam int DEF_ON_TICKS    = 2;
  localparam int DEF_OFF_TICKS   = 3;
  localparam int DEF_GAP_TICKS   = 10;
  localparam int MAX_REQ         = 32;

  // First valid index strictly after 'last', wrapping; scanned high to low so the nearest wins.
  function automatic int next_rr(input logic [MAX_REQ-1:0] valid, input int n, input int last);
    int result;
    int idx;
    result = 0;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= n) begin
        idx = (last + i) % n;
        if (valid[idx]) result = idx;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Tick prescaler: one-cycle tick every DIV cycles after clr; tick is constant 1 when DIV=1.
module blink_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (tick)     cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/blink_scheduler.sv
// Round-robin shared LED: grants one requester at a time and plays its blink code on q.
// Define BLINK_SCHED_ABORT_EN to add an abort input that cuts the current code short.
module blink_scheduler
  import blink_sched_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int CODE_W      = DEF_CODE_W,
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int TICK_HZ     = DEF_TICK_HZ,
  parameter int ON_TICKS    = DEF_ON_TICKS,
  parameter int OFF_TICKS   = DEF_OFF_TICKS,
  parameter int GAP_TICKS   = DEF_GAP_TICKS,
  localparam int AW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef BLINK_SCHED_ABORT_EN
  input  logic                      abort,
`endif
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*CODE_W-1:0] req_code,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic [AW-1:0]             active_id,
  output logic                      q
);

  // Handshake: req_valid[i] is held with a stable code until req_ready[i]; the single-cycle
  // req_ready pulse (only ever raised in IDLE) is the acceptance and latches the code.

  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int MAX_T01  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_T    = (MAX_T01 > GAP_TICKS) ? MAX_T01 : GAP_TICKS;
  localparam int TW       = (MAX_T > 1) ? $clog2(MAX_T + 1) : 1;

  state_e                state, state_next;
  logic   [CODE_W-1:0]   rem;
  logic   [TW-1:0]       tcnt;
  logic   [AW-1:0]       rr_last;
  logic   [NUM_REQ-1:0]  done_next;
  logic   [MAX_REQ-1:0]  valid_ext;
  logic   [CODE_W-1:0]   gnt_code;
  int                    gnt_idx;
  logic                  grant, clr, dec, tick;

  assign valid_ext = MAX_REQ'(req_valid);
  assign gnt_idx   = next_rr(valid_ext, NUM_REQ, int'(rr_last));
  assign gnt_code  = req_code[gnt_idx*CODE_W +: CODE_W];
  assign busy      = (state != IDLE);
  assign q         = (state == ON);

  blink_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    clr        = 1'b0;
    dec        = 1'b0;
    done_next  = '0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant              = 1'b1;
          req_ready[gnt_idx] = 1'b1;
          if (gnt_code == '0) done_next[gnt_idx] = 1'b1;
          else                state_next = ON;
        end
      end
      ON: begin
        if (tick && tcnt == TW'(ON_TICKS - 1)) begin
          dec        = 1'b1;
          // rem still holds the count before this blink's decrement
          state_next = (rem > CODE_W'(1)) ? OFF : GAP;
        end
      end
      OFF: begin
        if (tick && tcnt == TW'(OFF_TICKS - 1)) state_next = ON;
      end
      GAP: begin
        if (tick && tcnt == TW'(GAP_TICKS - 1)) begin
          state_next           = IDLE;
          done_next[active_id] = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef BLINK_SCHED_ABORT_EN
    if (abort && state != IDLE) begin
      state_next           = IDLE;
      dec                  = 1'b0;
      done_next            = '0;
      done_next[active_id] = 1'b1;
    end
`endif
    if (grant || state_next != state) clr = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      tcnt      <= '0;
      rr_last   <= AW'(NUM_REQ - 1);
      active_id <= '0;
      done      <= '0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (grant) begin
        rr_last   <= AW'(gnt_idx);
        active_id <= AW'(gnt_idx);
        rem       <= gnt_code;
      end else if (dec && rem != '0) begin
        rem <= rem - 1'b1;
      end
      if (clr)                        tcnt <= '0;
      else if (tick && state != IDLE) tcnt <= tcnt + 1'b1;
    end
  end

endmodule
